// File: rtl/lcd_bus_monitor_pkg.sv
// ============================================================================
// lcd_bus_monitor_pkg : HD44780 bus constants, FSM states and AC helpers
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_bus_monitor_pkg;

  localparam int         RS_BIT           = 9;
  localparam int         RW_BIT           = 8;
  localparam logic [6:0] LINE1_BASE       = 7'h00;
  localparam logic [6:0] LINE2_BASE       = 7'h40;
  localparam int         LINE_LEN         = 40;
  localparam int         DDRAM_SIZE       = 2 * LINE_LEN;
  localparam logic [7:0] CHAR_SPACE       = 8'h20;
  localparam int         DEF_CMD_BUSY_CYC = 2000;
  localparam int         DEF_CLR_BUSY_CYC = 82000;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_BUSY  = 2'd3
  } state_e;

  // Both lines share the column field in AC[5:0]; AC[6] selects the line.
  function automatic logic ac_valid(input logic [6:0] ac);
    return ac[5:0] < 6'(LINE_LEN);
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) begin
      if (ac[5:0] == 6'(LINE_LEN - 1))
        return ac[6] ? LINE1_BASE : LINE2_BASE;
      return ac + 7'd1;
    end
    if (ac[5:0] == 6'd0)
      return ac[6] ? (LINE1_BASE + 7'(LINE_LEN - 1)) : (LINE2_BASE + 7'(LINE_LEN - 1));
    return ac - 7'd1;
  endfunction

  function automatic logic [6:0] ac_to_idx(input logic [6:0] ac);
    return ac[6] ? (7'(LINE_LEN) + {1'b0, ac[5:0]}) : {1'b0, ac[5:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_monitor_en_sync.sv
// ============================================================================
// lcd_bus_monitor_en_sync : two-flop EN synchronizer with EN fall detect
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_monitor_en_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic [9:0] lcd_flag,
  output logic       fall_pulse,
  output logic [9:0] flag_q
);

  logic       en_s1_q, en_s1_d;
  logic       en_s2_q, en_s2_d;
  logic [9:0] flag_s1_q, flag_s1_d;
  logic [9:0] flag_s2_q, flag_s2_d;

  always_comb begin
    en_s1_d   = lcd_en;
    en_s2_d   = en_s1_q;
    flag_s1_d = lcd_flag;
    flag_s2_d = flag_s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      flag_s1_q <= '0;
      flag_s2_q <= '0;
    end else begin
      en_s1_q   <= en_s1_d;
      en_s2_q   <= en_s2_d;
      flag_s1_q <= flag_s1_d;
      flag_s2_q <= flag_s2_d;
    end
  end

  // flag_s2 was sampled together with the last EN-high sample, i.e. the bus
  // value present at the instant EN fell.
  assign fall_pulse = en_s2_q & ~en_s1_q;
  assign flag_q     = flag_s2_q;

endmodule

`default_nettype wire

// File: rtl/lcd_bus_monitor.sv
// ============================================================================
// lcd_bus_monitor : executes HD44780 bus transfers into a 2x40 DDRAM mirror
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_monitor
  import lcd_bus_monitor_pkg::*;
#(
  parameter int CMD_BUSY_CYC = DEF_CMD_BUSY_CYC,
  parameter int CLR_BUSY_CYC = DEF_CLR_BUSY_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_on,
  input  logic       lcd_en,
  input  logic [9:0] lcd_flag,
  input  logic       rd_row,
  input  logic [5:0] rd_col,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [6:0] addr_cnt,
  output logic       disp_on,
  output logic       cmd_valid,
  output logic [9:0] cmd_code,
  output logic       proto_err
);

  localparam int               CNT_W     = $clog2(CLR_BUSY_CYC);
  // Remaining ST_BUSY cycles; the ST_EXEC cycle (and walk) already count as busy.
  localparam logic [CNT_W-1:0] CMD_WAIT  = CNT_W'(CMD_BUSY_CYC - 1);
  localparam logic [CNT_W-1:0] HOME_WAIT = CNT_W'(CLR_BUSY_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_WAIT  = CNT_W'(CLR_BUSY_CYC - 1 - DDRAM_SIZE);

  logic       fall_pulse;
  logic [9:0] flag;

  lcd_bus_monitor_en_sync u_en_sync (
    .clk        (clk),
    .reset      (reset),
    .lcd_en     (lcd_en),
    .lcd_flag   (lcd_flag),
    .fall_pulse (fall_pulse),
    .flag_q     (flag)
  );

  state_e           state_q, state_d;
  logic [6:0]       walk_q, walk_d;
  logic             clr_cmd_q, clr_cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [6:0]       ac_q, ac_d;
  logic             inc_q, inc_d;
  logic             disp_on_q, disp_on_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [9:0]       cmd_code_q, cmd_code_d;
  logic             proto_err_q, proto_err_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic [7:0]       mem_q [DDRAM_SIZE];
  logic             mem_we;
  logic [6:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  logic [6:0]       rd_idx;

  always_comb begin
    state_d     = state_q;
    walk_d      = walk_q;
    clr_cmd_d   = clr_cmd_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    ac_d        = ac_q;
    inc_d       = inc_q;
    disp_on_d   = disp_on_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    proto_err_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = CHAR_SPACE;

    if (lcd_on) begin
      // busy_q is high in every state except ST_IDLE, so acceptance only starts from idle.
      if (fall_pulse) begin
        if (busy_q) begin
          proto_err_d = 1'b1;
        end else if (!flag[RS_BIT] && !flag[RW_BIT] && flag[7] && !ac_valid(flag[6:0])) begin
          proto_err_d = 1'b1;
        end else begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = flag;
          if (!flag[RW_BIT]) begin
            state_d = ST_EXEC;
            busy_d  = 1'b1;
          end
        end
      end

      case (state_q)
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = walk_q;
          if (walk_q == 7'(DDRAM_SIZE - 1)) begin
            walk_d    = '0;
            clr_cmd_d = 1'b0;
            if (clr_cmd_q) begin
              state_d = ST_BUSY;
              cnt_d   = CLR_WAIT;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            walk_d = walk_q + 7'd1;
          end
        end
        ST_EXEC: begin
          state_d = ST_BUSY;
          cnt_d   = CMD_WAIT;
          if (cmd_code_q[RS_BIT]) begin
            mem_we    = 1'b1;
            mem_waddr = ac_to_idx(ac_q);
            mem_wdata = cmd_code_q[7:0];
            ac_d      = ac_step(ac_q, inc_q);
          end else if (cmd_code_q[7]) begin
            ac_d = cmd_code_q[6:0];
          end else if (cmd_code_q[6] || cmd_code_q[5]) begin
            // CGRAM address / function set have no visible effect on the mirror.
          end else if (cmd_code_q[4]) begin
            if (!cmd_code_q[3])
              ac_d = ac_step(ac_q, cmd_code_q[2]);
          end else if (cmd_code_q[3]) begin
            disp_on_d = cmd_code_q[2];
          end else if (cmd_code_q[2]) begin
            inc_d = cmd_code_q[1];
          end else if (cmd_code_q[1]) begin
            ac_d  = '0;
            cnt_d = HOME_WAIT;
          end else if (cmd_code_q[0]) begin
            ac_d      = '0;
            inc_d     = 1'b1;
            walk_d    = '0;
            clr_cmd_d = 1'b1;
            state_d   = ST_CLEAR;
          end
        end
        ST_BUSY: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    rd_idx    = {1'b0, rd_col} + (rd_row ? 7'(LINE_LEN) : 7'd0);
    rd_data_d = (rd_col < 6'(LINE_LEN)) ? mem_q[rd_idx] : CHAR_SPACE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      walk_q      <= '0;
      clr_cmd_q   <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      ac_q        <= '0;
      inc_q       <= 1'b1;
      disp_on_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      proto_err_q <= 1'b0;
      rd_data_q   <= CHAR_SPACE;
    end else begin
      state_q     <= state_d;
      walk_q      <= walk_d;
      clr_cmd_q   <= clr_cmd_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ac_q        <= ac_d;
      inc_q       <= inc_d;
      disp_on_q   <= disp_on_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      proto_err_q <= proto_err_d;
      rd_data_q   <= rd_data_d;
      if (mem_we)
        mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign addr_cnt  = ac_q;
  assign disp_on   = disp_on_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_monitor.sv
// ============================================================================
// tb_lcd_bus_monitor : table-driven bench with transfer scoreboard
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_bus_monitor;

  localparam int CMD_CYC = 20;
  localparam int CLR_CYC = 200;

  logic       clk = 1'b0;
  logic       reset, lcd_on, lcd_en, rd_row;
  logic [9:0] lcd_flag;
  logic [5:0] rd_col;
  logic [7:0] rd_data;
  logic       busy, disp_on, cmd_valid, proto_err;
  logic [6:0] addr_cnt;
  logic [9:0] cmd_code;

  lcd_bus_monitor #(.CMD_BUSY_CYC(CMD_CYC), .CLR_BUSY_CYC(CLR_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .lcd_on    (lcd_on),
    .lcd_en    (lcd_en),
    .lcd_flag  (lcd_flag),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_data   (rd_data),
    .busy      (busy),
    .addr_cnt  (addr_cnt),
    .disp_on   (disp_on),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;

  typedef struct {
    logic       is_err;
    logic [9:0] code;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  typedef struct {
    logic [9:0] flag;
    logic [6:0] ac;
    logic       disp;
    logic       chk_rd;
    logic       row;
    logic [5:0] col;
    logic [7:0] rd;
  } vec_t;
  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each executed or dropped transfer is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (cmd_valid || proto_err) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", sb.size(), 1);
      end else begin
        sb_e = sb.pop_front();
        chk("sb_kind_err", proto_err, sb_e.is_err);
        if (!sb_e.is_err)
          chk("sb_cmd_code", cmd_code, sb_e.code);
      end
      if (cmd_valid) n_valid++;
      if (proto_err) n_err++;
    end
  end

  task automatic push(input logic is_err, input logic [9:0] code);
    sb_t e;
    e.is_err = is_err;
    e.code   = code;
    sb.push_back(e);
  endtask

  task automatic en_pulse(input logic [9:0] f);
    lcd_flag = f;
    lcd_en   = 1'b1;
    tick();
    tick();
    lcd_en = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk("busy_timeout", busy, 0);
  endtask

  task automatic send(input logic [9:0] f, input logic is_err);
    push(is_err, f);
    en_pulse(f);
    tick();
    tick();
    wait_idle();
  endtask

  task automatic rd_chk(input string name, input logic r, input logic [5:0] c, input logic [7:0] exp);
    rd_row = r;
    rd_col = c;
    tick();
    chk(name, rd_data, exp);
  endtask

  // Counting from the first cycle with reset released as cycle 1.
  task automatic reset_and_walk();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_rd_data", rd_data, 8'h20);
    chk("rst_busy", busy, 1);
    chk("rst_addr_cnt", addr_cnt, 0);
    chk("rst_disp_on", disp_on, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_code", cmd_code, 0);
    chk("rst_proto_err", proto_err, 0);
    reset = 1'b1;
    repeat (79) tick();
    chk("walk_busy_cycle80", busy, 1);
    tick();
    chk("walk_busy_cycle81", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv0, ne0;
    vecs[0]  = '{10'h038, 7'h00, 1'b0, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[1]  = '{10'h008, 7'h00, 1'b0, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[2]  = '{10'h001, 7'h00, 1'b0, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[3]  = '{10'h00C, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[4]  = '{10'h006, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[5]  = '{10'h242, 7'h01, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[6]  = '{10'h24F, 7'h02, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[7]  = '{10'h24D, 7'h03, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[8]  = '{10'h242, 7'h04, 1'b1, 1'b1, 1'b0, 6'd3,  8'h42};
    vecs[9]  = '{10'h0A7, 7'h27, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[10] = '{10'h241, 7'h40, 1'b1, 1'b1, 1'b0, 6'd39, 8'h41};
    vecs[11] = '{10'h014, 7'h41, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[12] = '{10'h010, 7'h40, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[13] = '{10'h010, 7'h27, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[14] = '{10'h0E7, 7'h67, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[15] = '{10'h014, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[16] = '{10'h004, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[17] = '{10'h258, 7'h67, 1'b1, 1'b1, 1'b0, 6'd0,  8'h58};
    vecs[18] = '{10'h002, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[19] = '{10'h018, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[20] = '{10'h000, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[21] = '{10'h006, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[22] = '{10'h0C0, 7'h40, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};
    vecs[23] = '{10'h251, 7'h41, 1'b1, 1'b1, 1'b1, 6'd0,  8'h51};
    vecs[24] = '{10'h002, 7'h00, 1'b1, 1'b0, 1'b0, 6'd0,  8'h00};

    reset    = 1'b0;
    lcd_on   = 1'b1;
    lcd_en   = 1'b0;
    lcd_flag = '0;
    rd_row   = 1'b0;
    rd_col   = '0;

    reset_and_walk();
    rd_chk("walk_rd_0_0", 1'b0, 6'd0, 8'h20);
    rd_chk("walk_rd_1_39", 1'b1, 6'd39, 8'h20);

    for (int i = 0; i < 25; i++) begin
      send(vecs[i].flag, 1'b0);
      chk($sformatf("vec%0d_addr_cnt", i), addr_cnt, vecs[i].ac);
      chk($sformatf("vec%0d_disp_on", i), disp_on, vecs[i].disp);
      if (vecs[i].chk_rd)
        rd_chk($sformatf("vec%0d_rd_data", i), vecs[i].row, vecs[i].col, vecs[i].rd);
    end

    rd_chk("rd_0_1", 1'b0, 6'd1, 8'h4F);
    rd_chk("rd_0_2", 1'b0, 6'd2, 8'h4D);
    rd_chk("rd_0_40_blank", 1'b0, 6'd40, 8'h20);
    rd_chk("rd_1_39", 1'b1, 6'd39, 8'h20);

    // Second fall lands inside the first transfer's busy window.
    nv0 = n_valid;
    ne0 = n_err;
    push(1'b0, 10'h006);
    en_pulse(10'h006);
    repeat (7) tick();
    push(1'b1, 10'h008);
    en_pulse(10'h008);
    tick();
    tick();
    wait_idle();
    chk("two_fall_valid_cnt", n_valid - nv0, 1);
    chk("two_fall_err_cnt", n_err - ne0, 1);
    chk("two_fall_disp_on", disp_on, 1);

    send(10'h085, 1'b0);
    chk("setac_addr_cnt", addr_cnt, 7'h05);
    send(10'h0B0, 1'b1);
    chk("bad_ac30_addr_cnt", addr_cnt, 7'h05);
    send(10'h0E8, 1'b1);
    chk("bad_ac68_addr_cnt", addr_cnt, 7'h05);

    nv0 = n_valid;
    ne0 = n_err;
    lcd_on = 1'b0;
    en_pulse(10'h001);
    en_pulse(10'h242);
    repeat (5) tick();
    chk("off_valid_cnt", n_valid - nv0, 0);
    chk("off_err_cnt", n_err - ne0, 0);
    chk("off_addr_cnt", addr_cnt, 7'h05);
    lcd_on = 1'b1;
    repeat (3) tick();
    rd_chk("off_rd_0_0", 1'b0, 6'd0, 8'h58);

    send(10'h100, 1'b0);
    chk("rw_read_addr_cnt", addr_cnt, 7'h05);

    send(10'h080, 1'b0);
    send(10'h25A, 1'b0);
    chk("pre_rst_addr_cnt", addr_cnt, 7'h01);
    rd_chk("pre_rst_rd_0_0", 1'b0, 6'd0, 8'h5A);
    push(1'b0, 10'h002);
    en_pulse(10'h002);
    repeat (50) tick();
    chk("mid_home_busy", busy, 1);
    reset_and_walk();
    rd_chk("post_rst_rd_0_0", 1'b0, 6'd0, 8'h20);
    rd_chk("post_rst_rd_0_3", 1'b0, 6'd3, 8'h20);

    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
